// File: rtl/order_reader_if.sv
// order_reader_if: bundles the receiver-side order/RAM signals and the PS-side word stream
// of order_reader.
//
//   master modport : the order_reader view (drives order_come, rd_add, m_*, status)
//   slave modport  : the environment view (drives user_req, order_full, wr_add, ram_data,
//                    m_ready)
//
// Signals
//   user_req    one-cycle pulse, user asks for one order
//   order_full  receiver cannot take another order
//   wr_add      receiver's current RAM write address
//   ram_data    RAM read data for rd_add
//   m_ready     PS-side consumer accepts m_data
//   order_come  one-cycle pulse issuing an order
//   rd_add      RAM read address
//   m_data      word presented to the PS side
//   m_valid     m_data valid
//   m_last      final word of an order
//   pend_count  user requests not yet issued
//   req_drop    one-cycle pulse, a user_req was discarded
//   ovf_err     sticky, a write arrived while the RAM held only unread words
interface order_reader_if #(
    parameter int unsigned FIFO_DATA = 25
);
    logic                 user_req;
    logic                 order_full;
    logic [6:0]           wr_add;
    logic [FIFO_DATA-1:0] ram_data;
    logic                 m_ready;

    logic                 order_come;
    logic [6:0]           rd_add;
    logic [FIFO_DATA-1:0] m_data;
    logic                 m_valid;
    logic                 m_last;
    logic [2:0]           pend_count;
    logic                 req_drop;
    logic                 ovf_err;

    modport master (
        input  user_req,
        input  order_full,
        input  wr_add,
        input  ram_data,
        input  m_ready,
        output order_come,
        output rd_add,
        output m_data,
        output m_valid,
        output m_last,
        output pend_count,
        output req_drop,
        output ovf_err
    );

    modport slave (
        output user_req,
        output order_full,
        output wr_add,
        output ram_data,
        output m_ready,
        input  order_come,
        input  rd_add,
        input  m_data,
        input  m_valid,
        input  m_last,
        input  pend_count,
        input  req_drop,
        input  ovf_err
    );
endinterface

// File: rtl/order_reader.sv
// order_reader: queues user order requests and issues them to the receiver one at a time,
// and independently streams words the receiver writes into a circular RAM out to the PS
// side through a valid/ready handshake.
//
// Ports
//   clk   single clock, all logic on the rising edge
//   rst   synchronous active-high reset
//   bus   order_reader_if master modport (see the interface file for signal meanings)
//
// Parameters
//   FIFO_DATA   data word width
//   ORDER_IMGS  words per order (m_last marks the final one)
//   RAM_DEPTH   RAM entries, addresses 0..RAM_DEPTH-1
module order_reader #(
    parameter int unsigned FIFO_DATA  = 25,
    parameter int unsigned ORDER_IMGS = 50,
    parameter int unsigned RAM_DEPTH  = 100
) (
    input  logic           clk,
    input  logic           rst,
    order_reader_if.master bus
);

    localparam int unsigned CntW = (ORDER_IMGS > 1) ? $clog2(ORDER_IMGS) : 1;
    localparam logic [CntW-1:0] LastIdx  = CntW'(ORDER_IMGS - 1);
    localparam logic [6:0]      AvailMax = 7'(RAM_DEPTH);
    localparam logic [6:0]      AddrMax  = 7'(RAM_DEPTH - 1);
    localparam logic [2:0]      PendMax  = 3'd7;

    typedef enum logic [1:0] {
        StIdle,
        StFetch,
        StHold
    } state_e;

    state_e               state_q;
    logic [2:0]           pend_q;
    logic                 order_come_q;
    logic                 req_drop_q;
    logic                 ovf_err_q;
    logic [6:0]           wr_add_q;
    logic [6:0]           avail_q;
    logic [6:0]           rd_add_q;
    logic [FIFO_DATA-1:0] m_data_q;
    logic                 m_valid_q;
    logic                 m_last_q;
    logic [CntW-1:0]      word_cnt_q;

    logic issue;
    logic wr_det;
    logic accept;

    // Blocking on order_come_q keeps issues at least two cycles apart.
    assign issue  = (pend_q != 3'd0) && !bus.order_full && !order_come_q;
    assign wr_det = (bus.wr_add != wr_add_q);
    assign accept = m_valid_q && bus.m_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            pend_q       <= '0;
            order_come_q <= 1'b0;
            req_drop_q   <= 1'b0;
            ovf_err_q    <= 1'b0;
            wr_add_q     <= '0;
            avail_q      <= '0;
            rd_add_q     <= '0;
            m_data_q     <= '0;
            m_valid_q    <= 1'b0;
            m_last_q     <= 1'b0;
            word_cnt_q   <= '0;
        end else begin
            // Request queue. A request arriving together with an issue leaves the count
            // unchanged; at saturation that pairing also avoids a drop.
            order_come_q <= issue;
            req_drop_q   <= bus.user_req && (pend_q == PendMax) && !issue;
            if (bus.user_req && !issue && (pend_q != PendMax)) begin
                pend_q <= pend_q + 3'd1;
            end else if (!bus.user_req && issue) begin
                pend_q <= pend_q - 3'd1;
            end

            // Any change of the receiver's write address is one new word.
            wr_add_q <= bus.wr_add;
            if (wr_det && !accept) begin
                if (avail_q == AvailMax) begin
                    ovf_err_q <= 1'b1;
                end else begin
                    avail_q <= avail_q + 7'd1;
                end
            end else if (accept && !wr_det) begin
                avail_q <= avail_q - 7'd1;
            end

            if (accept) begin
                rd_add_q   <= (rd_add_q == AddrMax) ? 7'd0 : rd_add_q + 7'd1;
                word_cnt_q <= (word_cnt_q == LastIdx) ? '0 : word_cnt_q + CntW'(1);
            end

            // Read FSM: FETCH gives the RAM a full cycle on a stable rd_add, HOLD presents
            // the captured word until it is accepted.
            case (state_q)
                StIdle: begin
                    if (avail_q != 7'd0) begin
                        state_q <= StFetch;
                    end
                end
                StFetch: begin
                    m_data_q  <= bus.ram_data;
                    m_valid_q <= 1'b1;
                    m_last_q  <= (word_cnt_q == LastIdx);
                    state_q   <= StHold;
                end
                StHold: begin
                    if (accept) begin
                        m_valid_q <= 1'b0;
                        m_last_q  <= 1'b0;
                        // avail_q still counts the word being accepted here.
                        state_q   <= (avail_q > 7'd1) ? StFetch : StIdle;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign bus.order_come = order_come_q;
    assign bus.rd_add     = rd_add_q;
    assign bus.m_data     = m_data_q;
    assign bus.m_valid    = m_valid_q;
    assign bus.m_last     = m_last_q;
    assign bus.pend_count = pend_q;
    assign bus.req_drop   = req_drop_q;
    assign bus.ovf_err    = ovf_err_q;

endmodule

// File: tb/tb_order_reader.sv
// Self-checking bench for order_reader: a behavioural RAM fed by a modelled receiver, a
// scoreboard queue of written words compared on every accepted word, and directed phases
// for the request queue, stalls, wrap-around, overflow and reset.
module tb_order_reader;

    localparam int unsigned FIFO_DATA  = 25;
    localparam int unsigned ORDER_IMGS = 50;
    localparam int unsigned RAM_DEPTH  = 100;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    order_reader_if #(.FIFO_DATA(FIFO_DATA)) bus ();

    order_reader #(
        .FIFO_DATA (FIFO_DATA),
        .ORDER_IMGS(ORDER_IMGS),
        .RAM_DEPTH (RAM_DEPTH)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // RAM read data follows rd_add within the cycle.
    logic [FIFO_DATA-1:0] mem [0:127];
    assign bus.ram_data = mem[bus.rd_add];

    int                   n_checks;
    int                   n_fail;
    logic [FIFO_DATA-1:0] sb_q [$];
    int                   acc_cnt;
    logic [6:0]           exp_rd;
    logic [6:0]           wa;
    int                   oc_cnt;
    int                   drop_cnt;
    int                   last_cnt;
    bit                   mon_en;

    logic                 prev_valid;
    logic                 prev_acc;
    logic                 prev_last;
    logic                 prev_oc;
    logic [FIFO_DATA-1:0] prev_data;
    logic [FIFO_DATA-1:0] exp_data;
    logic                 exp_last;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Monitor: samples on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (mon_en) begin
            if (bus.order_come) begin
                oc_cnt++;
                check("oc_spacing", 32'(prev_oc), 0);
            end
            if (bus.req_drop) drop_cnt++;
            if (prev_acc) begin
                check("read_gap", 32'(bus.m_valid), 0);
            end else if (prev_valid) begin
                check("hold_valid", 32'(bus.m_valid), 1);
                check("hold_data", 32'(bus.m_data), 32'(prev_data));
                check("hold_last", 32'(bus.m_last), 32'(prev_last));
            end
            if (bus.m_valid && bus.m_ready) begin
                if (bus.m_last) last_cnt++;
                check("rd_add", 32'(bus.rd_add), 32'(exp_rd));
                check("sb_has_word", 32'(sb_q.size() != 0), 1);
                if (sb_q.size() != 0) begin
                    exp_data = sb_q.pop_front();
                    exp_last = ((acc_cnt % ORDER_IMGS) == ORDER_IMGS - 1);
                    check("m_data", 32'(bus.m_data), 32'(exp_data));
                    check("m_last", 32'(bus.m_last), 32'(exp_last));
                end
                acc_cnt++;
                exp_rd = (exp_rd == 7'(RAM_DEPTH - 1)) ? 7'd0 : exp_rd + 7'd1;
            end
        end
        prev_valid = bus.m_valid;
        prev_acc   = bus.m_valid && bus.m_ready;
        prev_data  = bus.m_data;
        prev_last  = bus.m_last;
        prev_oc    = bus.order_come;
    end

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Receiver model: store a word at the write address, then advance the address.
    task automatic write_word(input bit track);
        logic [FIFO_DATA-1:0] d;
        d = FIFO_DATA'($urandom);
        mem[wa] = d;
        if (track) sb_q.push_back(d);
        wa = (wa == 7'(RAM_DEPTH - 1)) ? 7'd0 : wa + 7'd1;
        bus.wr_add = wa;
        tick();
    endtask

    task automatic pulse_req(input int n);
        repeat (n) begin
            bus.user_req = 1'b1;
            tick();
        end
        bus.user_req = 1'b0;
    endtask

    task automatic drain(input int max_cycles);
        int n;
        n = 0;
        while ((sb_q.size() != 0 || bus.m_valid) && n < max_cycles) begin
            tick();
            n++;
        end
        check("drain", 32'(sb_q.size()), 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_order_come"}, 32'(bus.order_come), 0);
        check({tag, "_m_valid"},    32'(bus.m_valid), 0);
        check({tag, "_m_last"},     32'(bus.m_last), 0);
        check({tag, "_req_drop"},   32'(bus.req_drop), 0);
        check({tag, "_ovf_err"},    32'(bus.ovf_err), 0);
        check({tag, "_rd_add"},     32'(bus.rd_add), 0);
        check({tag, "_m_data"},     32'(bus.m_data), 0);
        check({tag, "_pend"},       32'(bus.pend_count), 0);
    endtask

    initial begin
        int base_oc;
        int base_drop;
        int base_last;
        int base_acc;
        int n;

        n_checks = 0;
        n_fail   = 0;
        acc_cnt  = 0;
        exp_rd   = '0;
        wa       = '0;
        oc_cnt   = 0;
        drop_cnt = 0;
        last_cnt = 0;
        mon_en   = 1'b0;
        for (int i = 0; i < 128; i++) mem[i] = '0;

        rst            = 1'b1;
        bus.user_req   = 1'b0;
        bus.order_full = 1'b0;
        bus.wr_add     = '0;
        bus.m_ready    = 1'b0;
        tick(3);
        check_reset_outputs("reset");

        rst = 1'b0;
        tick(3);
        check("idle_after_reset", 32'(bus.m_valid), 0);
        check("avail_after_reset", 32'(dut.avail_q), 0);
        mon_en = 1'b1;

        // Three requests, free receiver.
        base_oc = oc_cnt;
        pulse_req(3);
        tick(10);
        check("three_orders", 32'(oc_cnt - base_oc), 3);
        check("three_pend", 32'(bus.pend_count), 0);

        // Saturation with the receiver full, then release.
        bus.order_full = 1'b1;
        base_oc   = oc_cnt;
        base_drop = drop_cnt;
        pulse_req(8);
        tick(3);
        check("sat_pend", 32'(bus.pend_count), 7);
        check("sat_drop", 32'(drop_cnt - base_drop), 1);
        check("sat_no_issue", 32'(oc_cnt - base_oc), 0);
        bus.order_full = 1'b0;
        tick(20);
        check("release_orders", 32'(oc_cnt - base_oc), 7);
        check("release_pend", 32'(bus.pend_count), 0);

        // One full order streamed with m_ready held high.
        bus.m_ready = 1'b1;
        base_last   = last_cnt;
        repeat (ORDER_IMGS) write_word(1'b1);
        drain(300);
        check("order_rd_add", 32'(bus.rd_add), 50);
        check("order_last_cnt", 32'(last_cnt - base_last), 1);

        // Stall in HOLD for ten cycles.
        bus.m_ready = 1'b0;
        write_word(1'b1);
        n = 0;
        while (!bus.m_valid && n < 10) begin
            tick();
            n++;
        end
        check("stall_hold", 32'(bus.m_valid), 1);
        tick(10);
        base_acc    = acc_cnt;
        bus.m_ready = 1'b1;
        tick();
        check("stall_accept", 32'(acc_cnt - base_acc), 1);
        drain(20);

        // Wrap of both addresses through 99 -> 0.
        repeat (60) write_word(1'b1);
        drain(300);
        check("wrap_rd_add", 32'(bus.rd_add), 11);

        // Fill the RAM with unread words, then one more.
        bus.m_ready = 1'b0;
        repeat (RAM_DEPTH) write_word(1'b0);
        tick(3);
        check("full_no_ovf", 32'(bus.ovf_err), 0);
        check("full_avail", 32'(dut.avail_q), RAM_DEPTH);
        write_word(1'b0);
        tick(3);
        check("ovf_set", 32'(bus.ovf_err), 1);
        check("ovf_avail", 32'(dut.avail_q), RAM_DEPTH);

        // Reset while holding a word with three requests pending.
        bus.order_full = 1'b1;
        pulse_req(3);
        tick();
        check("pre_rst_pend", 32'(bus.pend_count), 3);
        check("pre_rst_hold", 32'(bus.m_valid), 1);
        mon_en     = 1'b0;
        wa         = '0;
        bus.wr_add = '0;
        rst        = 1'b1;
        tick();
        check_reset_outputs("mid_rst");
        rst            = 1'b0;
        bus.order_full = 1'b0;
        sb_q.delete();
        acc_cnt = 0;
        exp_rd  = '0;
        tick();
        check("post_rst_oc", 32'(bus.order_come), 0);
        check("post_rst_valid", 32'(bus.m_valid), 0);
        mon_en = 1'b1;
        tick(3);
        check("post_rst_avail", 32'(dut.avail_q), 0);

        // Fresh traffic after reset starts from address 0.
        bus.m_ready = 1'b1;
        repeat (3) write_word(1'b1);
        drain(50);
        check("post_rst_rd_add", 32'(bus.rd_add), 3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/order_reader.md
ORDER_READER -- requirements
Module: order_reader

Interface
REQ-001 Parameter FIFO_DATA, default 25, data word width.
REQ-002 Parameter ORDER_IMGS, default 50, words per order.
REQ-003 Parameter RAM_DEPTH, default 100, RAM block entries (addresses 0..RAM_DEPTH-1).
REQ-004 clk  in  1  single clock; all logic on rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 user_req  in  1  one-cycle pulse: user requests one order.
REQ-007 order_full  in  1  receiver cannot accept further orders.
REQ-008 wr_add  in  7  receiver's current RAM write address.
REQ-009 ram_data  in  FIFO_DATA  RAM read data, valid one cycle after rd_add.
REQ-010 m_ready  in  1  PS-side consumer accepts m_data.
REQ-011 order_come  out  1  one-cycle pulse issuing an order to the receiver.
REQ-012 rd_add  out  7  RAM read address.
REQ-013 m_data  out  FIFO_DATA  word presented to PS side.
REQ-014 m_valid  out  1  m_data valid.
REQ-015 m_last  out  1  high with m_valid on final word of an order.
REQ-016 pend_count  out  3  user requests not yet issued.
REQ-017 req_drop  out  1  one-cycle pulse: user_req discarded.
REQ-018 ovf_err  out  1  sticky: write seen with RAM full of unread words.

Function
REQ-019 Request queue: user_req increments pend_count; pend_count saturates at 7; user_req at 7 -> pend_count unchanged, req_drop pulses next cycle.
REQ-020 Issue: order_come pulses one cycle when pend_count>0 and order_full==0; pend_count decrements same edge; at most one issue per 2 cycles (order_come never high two consecutive cycles).
REQ-021 Simultaneous user_req and issue: pend_count unchanged (unless pend_count==7, then issue and no drop).
REQ-022 Write detect: register wr_add into wr_add_q each cycle; wr_add != wr_add_q counts as exactly one new word.
REQ-023 avail counter (0..RAM_DEPTH, 7 bits): +1 on write detect, -1 on word accept (m_valid&&m_ready), unchanged when both same cycle.
REQ-024 Write detect with avail==RAM_DEPTH and no accept -> avail holds, ovf_err set, cleared only by rst.
REQ-025 rd_add wraps RAM_DEPTH-1 -> 0; advances by 1 on each word accept only.
REQ-026 FSM states IDLE, FETCH, HOLD.
REQ-027 IDLE: m_valid=0; avail>0 -> FETCH.
REQ-028 FETCH: one cycle, rd_add stable; next edge captures ram_data into m_data, -> HOLD.
REQ-029 HOLD: m_valid=1, m_data and m_last stable until m_ready; on accept: avail>1 -> FETCH, else IDLE.
REQ-030 m_valid never drops without accept (no retraction).
REQ-031 word counter 0..ORDER_IMGS-1 counts accepted words; m_last=1 in HOLD when counter==ORDER_IMGS-1; counter returns to 0 on that accept.
REQ-032 Throughput: one word per 2 cycles max with m_ready held high.
REQ-033 Read side independent of order issue; reads proceed whenever avail>0.

Reset
REQ-034 rst high at a rising edge -> state IDLE; order_come, m_valid, m_last, req_drop, ovf_err = 0; rd_add, m_data, pend_count, avail, word counter, wr_add_q = 0.
REQ-035 rst mid-transfer discards held word, pending requests and counts; no order_come or m_valid in the cycle after reset release.
REQ-036 wr_add_q loads 0 on reset; first post-reset wr_add=0 gives no write detect.

Verification
REQ-037 Three user_req pulses, order_full=0 -> three order_come pulses, spaced >=2 cycles, pend_count 0 at end.
REQ-038 order_full=1, eight user_req -> pend_count=7, one req_drop, no order_come; release order_full -> seven order_come pulses.
REQ-039 wr_add steps 0..50, m_ready=1 -> 50 words in RAM order, rd_add ends 50, m_last only on word 50, m_valid 1 cycle of every 2.
REQ-040 m_ready low for 10 cycles in HOLD -> m_data, m_last stable, m_valid held; word accepted on first m_ready high.
REQ-041 wr_add wraps 99 -> 0 across read -> rd_add wraps 99 -> 0, no word lost/duplicated; 101st unread write -> ovf_err=1, avail=100.
REQ-042 rst during HOLD with pend_count=3 -> all outputs reset values next cycle, no stale m_valid.
